// File: rtl/aes_round_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : aes_round_ctrl_if
//  Description : Bundle of the block-source handshake and the single-round
//                datapath hookup used by the AES-256 round sequencer.
//                master = block source + round unit side, slave = sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface aes_round_ctrl_if #(
    parameter int NR      = 14,
    parameter int NK_BITS = (NR + 1) * 128
);
    // Block source side
    logic               start;
    logic               abort;
    logic               mode;
    logic [127:0]       din;
    logic [NK_BITS-1:0] expanded_key;
    logic               busy;
    logic               done;
    logic [127:0]       dout;

    // Round unit side
    logic [127:0]       rnd_state;
    logic [127:0]       rnd_key;
    logic [3:0]         rnd_idx;
    logic               rnd_last;
    logic               rnd_inv;
    logic [127:0]       rnd_result;

    modport master (
        output start, abort, mode, din, expanded_key, rnd_result,
        input  busy, done, dout, rnd_state, rnd_key, rnd_idx, rnd_last, rnd_inv
    );

    modport slave (
        input  start, abort, mode, din, expanded_key, rnd_result,
        output busy, done, dout, rnd_state, rnd_key, rnd_idx, rnd_last, rnd_inv
    );
endinterface
`default_nettype wire

// File: rtl/aes_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : aes_round_ctrl
//  Description : Iterative AES-256 round sequencer. Performs the initial
//                AddRoundKey, then steps an external combinational round unit
//                through 14 rounds (encrypt: keys 1..14, decrypt: 13..0).
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_round_ctrl #(
    parameter int NR      = 14,
    parameter int NK_BITS = 1920
) (
    input  logic            clk,
    input  logic            rst_n,
    aes_round_ctrl_if.slave bus
);

    localparam logic [3:0] c_LAST_RND = 4'(NR);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [3:0]   rnd_q,   rnd_d;
    logic [127:0] st_q,    st_d;
    logic         mode_q,  mode_d;
    logic [127:0] dout_q,  dout_d;

    // Round-key table; entry 15 is padding so a 4-bit index never leaves it.
    logic [127:0] w_key_tbl [16];

    for (genvar k = 0; k < 16; k++) begin : g_key
        if (k <= NR) begin : g_used
            assign w_key_tbl[k] = bus.expanded_key[NK_BITS-1-128*k -: 128];
        end else begin : g_pad
            assign w_key_tbl[k] = '0;
        end
    end

    // State, round counter and latched operands; reset acts immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            st_q    <= '0;
            mode_q  <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            st_q    <= st_d;
            mode_q  <= mode_d;
            dout_q  <= dout_d;
        end
    end

    // Next-state: accept in IDLE/DONE, iterate in ROUND, abort only mid-run.
    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        st_d    = st_q;
        mode_d  = mode_q;
        dout_d  = dout_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    // Initial AddRoundKey uses key 14 when decrypting.
                    st_d    = bus.din ^ (bus.mode ? w_key_tbl[c_LAST_RND] : w_key_tbl[0]);
                    rnd_d   = 4'd1;
                    mode_d  = bus.mode;
                    state_d = ROUND;
                end else begin
                    state_d = IDLE;
                end
            end
            ROUND: begin
                if (bus.abort) begin
                    rnd_d   = '0;
                    state_d = IDLE;
                end else begin
                    st_d = bus.rnd_result;
                    if (rnd_q == c_LAST_RND) begin
                        dout_d  = bus.rnd_result;
                        rnd_d   = '0;
                        state_d = DONE;
                    end else begin
                        rnd_d = rnd_q + 4'd1;
                    end
                end
            end
            default: begin
                rnd_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from registers only, so the round unit sees no loop.
    always_comb begin
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.dout      = dout_q;
        bus.rnd_state = st_q;
        bus.rnd_key   = '0;
        bus.rnd_idx   = '0;
        bus.rnd_last  = 1'b0;
        bus.rnd_inv   = mode_q;
        if (state_q == ROUND) begin
            bus.busy     = 1'b1;
            bus.rnd_idx  = rnd_q;
            bus.rnd_key  = w_key_tbl[mode_q ? (c_LAST_RND - rnd_q) : rnd_q];
            bus.rnd_last = (rnd_q == c_LAST_RND);
        end
        if (state_q == DONE) begin
            bus.done = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_round_ctrl
//  Description : Scoreboard bench for aes_round_ctrl with an AES round model
//                standing in for the external round unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_round_ctrl;

    localparam logic [255:0] c_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] c_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    aes_round_ctrl_if bus ();

    aes_round_ctrl #(.NR(14), .NK_BITS(1920)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [127:0] dout;
        logic         mode;
        int           start_cyc;
        bit           completes;
    } exp_t;

    exp_t         sb [$];
    logic [7:0]   sbox  [256];
    logic [7:0]   isbox [256];
    logic [127:0] ks    [15];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    // Reference single round: forward cipher, or straightforward inverse
    // cipher (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns).
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last, input logic inv);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [7:0]   m [16];
        logic [7:0]   cf [4];
        logic [7:0]   acc;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                b[r+4*c] = inv ? isbox[a[r+4*((c-r+4)%4)]] : sbox[a[r+4*((c+r)%4)]];
        if (inv) for (int i = 0; i < 16; i++) b[i] = b[i] ^ k[127-8*i -: 8];
        if (inv) begin cf[0] = 8'd14; cf[1] = 8'd11; cf[2] = 8'd13; cf[3] = 8'd9; end
        else     begin cf[0] = 8'd2;  cf[1] = 8'd3;  cf[2] = 8'd1;  cf[3] = 8'd1; end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) acc = acc ^ gmul(b[4*c+j], cf[(j-r+4)%4]);
                m[4*c+r] = last ? b[4*c+r] : acc;
            end
        if (!inv) for (int i = 0; i < 16; i++) m[i] = m[i] ^ k[127-8*i -: 8];
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = m[i];
        return o;
    endfunction

    // Round unit model
    always_comb bus.rnd_result = aes_round(bus.rnd_state, bus.rnd_key, bus.rnd_last, bus.rnd_inv);

    // Monitor: per-cycle round checks and scoreboard pop on done
    exp_t mon_e;
    int   exp_idx = 0;
    bit   prev_busy = 1'b0;
    always @(negedge clk) begin
        if (bus.done) begin
            chk("busy_in_done", bus.busy, 1'b0);
            chk("sb_nonempty_at_done", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("done_not_aborted", mon_e.completes, 1'b1);
                chk("dout", bus.dout, mon_e.dout);
                chk("latency", cyc - mon_e.start_cyc, 15);
            end
        end else if (bus.busy) begin
            exp_idx = prev_busy ? exp_idx + 1 : 1;
            chk("sb_nonempty_at_busy", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                chk("rnd_idx", bus.rnd_idx, exp_idx);
                chk("rnd_last", bus.rnd_last, exp_idx == 14);
                chk("rnd_inv", bus.rnd_inv, sb[0].mode);
                if (exp_idx <= 14)
                    chk("rnd_key", bus.rnd_key, ks[sb[0].mode ? 14 - exp_idx : exp_idx]);
            end
        end else begin
            chk("idle_rnd_idx", bus.rnd_idx, 4'd0);
            chk("idle_rnd_key", bus.rnd_key, 128'd0);
            chk("idle_rnd_last", bus.rnd_last, 1'b0);
        end
        prev_busy = bus.busy;
    end

    task automatic push_exp(input logic [127:0] d, input logic m, input int sc, input bit comp);
        exp_t e;
        e.dout = d; e.mode = m; e.start_cyc = sc; e.completes = comp;
        sb.push_back(e);
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 after accept.
    task automatic start_block(input logic [127:0] d, input logic m, input logic [127:0] exp, input bit comp);
        bus.din = d; bus.mode = m; bus.start = 1'b1;
        push_exp(exp, m, cyc, comp);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.din = ~d; bus.mode = ~m;
    endtask

    task automatic wait_idx(input logic [3:0] idx);
        int n = 0;
        while (bus.rnd_idx !== idx && n < 30) begin @(posedge clk); #1; n++; end
        chk("reach_rnd_idx", bus.rnd_idx, idx);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
        chk("drain", sb.size(), 0);
        sb.delete();
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},      bus.busy, 1'b0);
        chk({tag, "_done"},      bus.done, 1'b0);
        chk({tag, "_dout"},      bus.dout, 128'd0);
        chk({tag, "_rnd_state"}, bus.rnd_state, 128'd0);
        chk({tag, "_rnd_key"},   bus.rnd_key, 128'd0);
        chk({tag, "_rnd_idx"},   bus.rnd_idx, 4'd0);
        chk({tag, "_rnd_last"},  bus.rnd_last, 1'b0);
        chk({tag, "_rnd_inv"},   bus.rnd_inv, 1'b0);
    endtask

    // Driver
    initial begin
        logic [7:0]  inv, sv, cst;
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int          n0;

        bus.start = 1'b0; bus.abort = 1'b0; bus.mode = 1'b0; bus.din = '0; bus.expanded_key = '0;

        // S-box tables from GF(2^8) inverse plus affine map
        cst = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                inv = 8'h01;
                for (int j = 0; j < 254; j++) inv = gmul(inv, 8'(x));
            end
            for (int i = 0; i < 8; i++)
                sv[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
            sbox[x] = sv;
            isbox[sv] = 8'(x);
        end

        // AES-256 key expansion
        for (int i = 0; i < 8; i++) w[i] = c_KEY[255-32*i -: 32];
        rc = 8'h01;
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                t = subword(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int k = 0; k < 15; k++) begin
            ks[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
            bus.expanded_key[1919-128*k -: 128] = ks[k];
        end

        // Reset
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Encrypt then decrypt the FIPS-197 vector
        start_block(c_PT, 1'b0, c_CT, 1'b1);
        wait_idle();
        start_block(c_CT, 1'b1, c_PT, 1'b1);
        wait_idle();

        // Start pulses during ROUND, including on the edge that enters DONE
        start_block(c_PT, 1'b0, c_CT, 1'b1);
        repeat (3) @(posedge clk);
        #1 bus.start = 1'b1; bus.din = 128'h0123456789abcdef0123456789abcdef; bus.mode = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        wait_idle();

        // Back-to-back: three blocks with start held; abort in DONE loses to start
        n0 = cyc;
        push_exp(c_CT, 1'b0, n0, 1'b1);
        push_exp(c_PT, 1'b1, n0 + 15, 1'b1);
        push_exp(c_CT, 1'b0, n0 + 30, 1'b1);
        bus.din = c_PT; bus.mode = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1 bus.din = c_CT; bus.mode = 1'b1;
        repeat (14) @(posedge clk);
        #1 bus.abort = 1'b1;
        @(posedge clk); #1 bus.abort = 1'b0; bus.din = c_PT; bus.mode = 1'b0;
        repeat (15) @(posedge clk);
        #1 bus.start = 1'b0; bus.din = '1; bus.mode = 1'b1;
        wait_idle();

        // Abort at round 7: dout keeps the previous ciphertext
        start_block(c_PT, 1'b0, c_CT, 1'b0);
        wait_idx(4'd7);
        bus.abort = 1'b1;
        @(posedge clk); #1 bus.abort = 1'b0;
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_done", bus.done, 1'b0);
        chk("abort_dout_kept", bus.dout, c_CT);
        chk("abort_rnd_idx", bus.rnd_idx, 4'd0);
        if (sb.size() != 0) void'(sb.pop_front());
        repeat (20) @(posedge clk);
        #1;
        start_block(c_CT, 1'b1, c_PT, 1'b1);
        wait_idle();

        // Asynchronous reset at round 5 of a decrypt
        start_block(c_CT, 1'b1, c_PT, 1'b0);
        wait_idx(4'd5);
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_mid");
        if (sb.size() != 0) void'(sb.pop_front());
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        start_block(c_PT, 1'b0, c_CT, 1'b1);
        wait_idle();

        chk("sb_empty_end", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks %0d/%0d", n_pass, n_checks);
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
